// File: rtl/bfifo_pkg.sv
`default_nettype none
// ==== bfifo_pkg: shared defaults for the bfifo read-side packer ==== rev 1.0 ====
package bfifo_pkg;

  localparam int BFIFO_DWIDTH    = 3;
  localparam int BFIFO_PACK_NUM  = 8;
  localparam int BFIFO_CNT_WIDTH = 4;
  localparam int BFIFO_TOT_WIDTH = 16;
  localparam int BFIFO_PKT_WIDTH = BFIFO_DWIDTH * BFIFO_PACK_NUM;

endpackage
`default_nettype wire

// File: rtl/bfifo_pkt_oreg.sv
`default_nettype none
// ==== bfifo_pkt_oreg: packet output register, valid/ready hold, accept counter ==== rev 1.0 ====
module bfifo_pkt_oreg
  import bfifo_pkg::*;
#(
  parameter int PKT_WIDTH = BFIFO_PKT_WIDTH,
  parameter int CNT_WIDTH = BFIFO_CNT_WIDTH,
  parameter int TOT_WIDTH = BFIFO_TOT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PKT_WIDTH-1:0] load_data,
  input  logic [CNT_WIDTH-1:0] load_cnt,
  output logic [PKT_WIDTH-1:0] pkt_data,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [TOT_WIDTH-1:0] pkt_total
);

  logic w_accept;

  assign w_accept = pkt_valid && pkt_ready;

  // A load in the same cycle as an accept replaces the packet without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_data  <= '0;
      pkt_cnt   <= '0;
      pkt_valid <= 1'b0;
      pkt_total <= '0;
    end else begin
      if (load) begin
        pkt_data  <= load_data;
        pkt_cnt   <= load_cnt;
        pkt_valid <= 1'b1;
      end else if (w_accept) begin
        pkt_valid <= 1'b0;
      end
      if (w_accept) begin
        pkt_total <= pkt_total + TOT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bfifo_rd_packer.sv
`default_nettype none
// ==== bfifo_rd_packer: packs PACK_NUM FWFT FIFO words into valid/ready packets ==== rev 1.0 ====
module bfifo_rd_packer
  import bfifo_pkg::*;
#(
  parameter int DWIDTH    = BFIFO_DWIDTH,
  parameter int PACK_NUM  = BFIFO_PACK_NUM,
  parameter int CNT_WIDTH = BFIFO_CNT_WIDTH,
  parameter int TOT_WIDTH = BFIFO_TOT_WIDTH
) (
  input  logic                         RCLOCK,
  input  logic                         RESET,
  input  logic                         FIFO_EMPTY,
  input  logic [DWIDTH-1:0]            FIFO_RDATA,
  output logic                         FIFO_RE,
  input  logic                         FLUSH,
  output logic [DWIDTH*PACK_NUM-1:0]   PKT_DATA,
  output logic [CNT_WIDTH-1:0]         PKT_CNT,
  output logic                         PKT_VALID,
  input  logic                         PKT_READY,
  output logic [TOT_WIDTH-1:0]         PKT_TOTAL,
  output logic                         BUSY
);

  localparam int                   PKT_WIDTH = DWIDTH * PACK_NUM;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(PACK_NUM);

  logic [PACK_NUM-1:0][DWIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]            r_wcnt;
  logic                            r_flush_pend;

  logic                            w_ofree;
  logic                            w_xfer;
  logic                            w_pop;
  logic [CNT_WIDTH-1:0]            w_slot;
  logic [PKT_WIDTH-1:0]            w_load_data;

  assign w_ofree = !PKT_VALID || PKT_READY;
  assign w_xfer  = w_ofree && ((r_wcnt == FULL_CNT) || (r_flush_pend && (r_wcnt != '0)));
  assign w_pop   = !RESET && !FIFO_EMPTY && !r_flush_pend && ((r_wcnt < FULL_CNT) || w_xfer);
  assign w_slot  = w_xfer ? '0 : r_wcnt;
  assign FIFO_RE = w_pop;
  assign BUSY    = (r_wcnt != '0) || r_flush_pend || PKT_VALID;

  // Stale words beyond the current fill level are masked so short packets carry zeros.
  generate
    for (genvar k = 0; k < PACK_NUM; k++) begin : g_mask
      assign w_load_data[k*DWIDTH +: DWIDTH] = (CNT_WIDTH'(k) < r_wcnt) ? r_acc[k] : '0;
    end
  endgenerate

  always_ff @(posedge RCLOCK) begin
    if (RESET) begin
      r_acc <= '0;
    end else begin
      for (int k = 0; k < PACK_NUM; k++) begin
        if (w_pop && (w_slot == CNT_WIDTH'(k))) begin
          r_acc[k] <= FIFO_RDATA;
        end
      end
    end
  end

  // A pending flush with a full accumulator simply rides out on the full-packet transfer.
  always_ff @(posedge RCLOCK) begin
    if (RESET) begin
      r_wcnt       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_wcnt <= w_pop ? CNT_WIDTH'(1) : '0;
      end else if (w_pop) begin
        r_wcnt <= r_wcnt + CNT_WIDTH'(1);
      end

      if (r_flush_pend) begin
        if (w_xfer || (r_wcnt == '0)) begin
          r_flush_pend <= 1'b0;
        end
      end else if (FLUSH) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  bfifo_pkt_oreg #(
    .PKT_WIDTH (PKT_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .TOT_WIDTH (TOT_WIDTH)
  ) u_oreg (
    .clk       (RCLOCK),
    .rst       (RESET),
    .load      (w_xfer),
    .load_data (w_load_data),
    .load_cnt  (r_wcnt),
    .pkt_data  (PKT_DATA),
    .pkt_cnt   (PKT_CNT),
    .pkt_valid (PKT_VALID),
    .pkt_ready (PKT_READY),
    .pkt_total (PKT_TOTAL)
  );

endmodule
`default_nettype wire

// File: tb/tb_bfifo_rd_packer.sv
`default_nettype none
// ==== tb_bfifo_rd_packer: directed scoreboard bench for bfifo_rd_packer ==== rev 1.0 ====
module tb_bfifo_rd_packer;
  import bfifo_pkg::*;

  localparam int DW = BFIFO_DWIDTH;
  localparam int PN = BFIFO_PACK_NUM;
  localparam int CW = BFIFO_CNT_WIDTH;
  localparam int TW = BFIFO_TOT_WIDTH;
  localparam int PW = BFIFO_PKT_WIDTH;

  logic          RCLOCK     = 1'b0;
  logic          RESET      = 1'b1;
  logic          FIFO_EMPTY = 1'b1;
  logic [DW-1:0] FIFO_RDATA = '0;
  logic          FIFO_RE;
  logic          FLUSH      = 1'b0;
  logic [PW-1:0] PKT_DATA;
  logic [CW-1:0] PKT_CNT;
  logic          PKT_VALID;
  logic          PKT_READY  = 1'b0;
  logic [TW-1:0] PKT_TOTAL;
  logic          BUSY;

  typedef struct packed {
    logic [PW-1:0] d;
    logic [CW-1:0] c;
  } pkt_t;

  pkt_t          sb_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];

  int tests       = 0;
  int fails       = 0;
  int total_model = 0;
  int re_count    = 0;
  int cur_run     = 0;
  int max_run     = 0;

  always #5 RCLOCK = ~RCLOCK;

  bfifo_rd_packer dut (
    .RCLOCK     (RCLOCK),
    .RESET      (RESET),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RDATA (FIFO_RDATA),
    .FIFO_RE    (FIFO_RE),
    .FLUSH      (FLUSH),
    .PKT_DATA   (PKT_DATA),
    .PKT_CNT    (PKT_CNT),
    .PKT_VALID  (PKT_VALID),
    .PKT_READY  (PKT_READY),
    .PKT_TOTAL  (PKT_TOTAL),
    .BUSY       (BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    FIFO_EMPTY = (fifo_q.size() == 0);
    FIFO_RDATA = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic fifo_push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_sync();
  endtask

  // Reference packer: closes a packet from the pending words, first word in the LSBs.
  task automatic close_pkt();
    pkt_t p;
    p.d = '0;
    p.c = CW'(pend_q.size());
    for (int i = 0; i < pend_q.size(); i++) p.d[i*DW +: DW] = pend_q[i];
    if (pend_q.size() != 0) sb_q.push_back(p);
    pend_q.delete();
  endtask

  task automatic model_push(input logic [DW-1:0] w);
    fifo_push(w);
    pend_q.push_back(w);
    if (pend_q.size() == PN) close_pkt();
  endtask

  task automatic tick();
    logic re_pre;
    logic acc_pre;
    pkt_t dummy;
    #4;
    re_pre  = (FIFO_RE === 1'b1);
    acc_pre = (PKT_VALID === 1'b1) && (PKT_READY === 1'b1);
    @(posedge RCLOCK);
    #1;
    if (re_pre) begin
      if (fifo_q.size() != 0) dummy.d[DW-1:0] = fifo_q.pop_front();
      re_count++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    fifo_sync();
    if (acc_pre) begin
      chk("accept_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) dummy = sb_q.pop_front();
      total_model++;
    end
    chk("pkt_total", PKT_TOTAL, TW'(total_model));
    if (PKT_VALID === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", PKT_VALID, 0);
      end else begin
        chk("pkt_data", PKT_DATA, sb_q[0].d);
        chk("pkt_cnt", PKT_CNT, sb_q[0].c);
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && (sb_q.size() != 0 || PKT_VALID === 1'b1 || fifo_q.size() != 0); i++)
      tick();
    chk({"drain_", tag}, sb_q.size() + ((PKT_VALID === 1'b1) ? 1 : 0), 0);
  endtask

  initial begin
    // Reset state; FIFO_RE must stay low under reset even with data waiting
    tick();
    tick();
    chk("rst_valid", PKT_VALID, 0);
    chk("rst_data", PKT_DATA, 0);
    chk("rst_cnt", PKT_CNT, 0);
    chk("rst_total", PKT_TOTAL, 0);
    chk("rst_busy", BUSY, 0);
    fifo_push(3'd3);
    #1;
    chk("rst_re", FIFO_RE, 0);
    tick();
    fifo_q.delete();
    fifo_sync();
    RESET = 1'b0;
    PKT_READY = 1'b1;
    tick();

    // Continuous stream 0..7 twice, ready held high
    for (int i = 0; i < 16; i++) fifo_push(DW'(i % 8));
    sb_q.push_back('{d: 24'hFAC688, c: 4'd8});
    sb_q.push_back('{d: 24'hFAC688, c: 4'd8});
    max_run = 0;
    cur_run = 0;
    drain("stream");
    chk("stream_run", max_run, 16);
    chk("stream_total", PKT_TOTAL, 2);

    // Three words then flush
    fifo_push(3'd5);
    fifo_push(3'd6);
    fifo_push(3'd7);
    sb_q.push_back('{d: 24'h0001F5, c: 4'd3});
    tick();
    tick();
    tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush_lat1", PKT_VALID, 0);
    tick();
    chk("flush_lat2", PKT_VALID, 1);
    chk("flush_cnt", PKT_CNT, 3);
    drain("flush3");

    // Flush with nothing accumulated
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush0_busy_pend", BUSY, 1);
    tick();
    chk("flush0_busy_clr", BUSY, 0);
    chk("flush0_valid_a", PKT_VALID, 0);
    tick();
    chk("flush0_valid_b", PKT_VALID, 0);

    // Backpressure with a full FIFO
    PKT_READY = 1'b0;
    for (int i = 0; i < 3 * PN; i++) model_push(DW'($urandom_range(0, 7)));
    re_count = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_lat_before", PKT_VALID, 0);
    tick();
    chk("bp_lat_after", PKT_VALID, 1);
    for (int i = 0; i < 11; i++) tick();
    chk("bp_pops", re_count, 16);
    chk("bp_stall_re", FIFO_RE, 0);
    chk("bp_busy", BUSY, 1);
    PKT_READY = 1'b1;
    drain("bp");
    chk("bp_total", PKT_TOTAL, 6);

    // Flush coincident with the 4th pop
    for (int i = 0; i < 4; i++) model_push(DW'(7 - i));
    tick();
    tick();
    tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    close_pkt();
    tick();
    chk("flush4_valid", PKT_VALID, 1);
    chk("flush4_cnt", PKT_CNT, 4);
    drain("flush4");

    // Reset with wcnt=5 and a packet held
    PKT_READY = 1'b0;
    for (int i = 0; i < PN + 5; i++) model_push(DW'($urandom_range(0, 7)));
    for (int i = 0; i < PN + 5; i++) tick();
    chk("mid_valid", PKT_VALID, 1);
    chk("mid_busy", BUSY, 1);
    sb_q.delete();
    pend_q.delete();
    total_model = 0;
    RESET = 1'b1;
    model_push(3'd6);
    #1;
    chk("mid_rst_re", FIFO_RE, 0);
    tick();
    chk("mid_rst_valid", PKT_VALID, 0);
    chk("mid_rst_data", PKT_DATA, 0);
    chk("mid_rst_cnt", PKT_CNT, 0);
    chk("mid_rst_total", PKT_TOTAL, 0);
    chk("mid_rst_busy", BUSY, 0);
    RESET = 1'b0;
    PKT_READY = 1'b1;
    for (int i = 0; i < PN - 1; i++) model_push(DW'(i));
    drain("post_rst");
    chk("post_rst_total", PKT_TOTAL, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bfifo_rd_packer.md
# bfifo_rd_packer

Read-side consumer for the 3-bit-wide bfifo channel FIFOs in the AI path. It pops words from a first-word-fall-through FIFO read port and packs `PACK_NUM` consecutive words into one wide packet. It presents each packet downstream on a valid/ready handshake. A flush request closes a partial packet early. It sits in the read clock domain, between the FIFO and the frame assembly logic.

## Interface
Parameters:
- `DWIDTH`, 3, FIFO word width.
- `PACK_NUM`, 8, words per full packet; legal range 2..15.
- `CNT_WIDTH`, 4, width of word counters; must hold `PACK_NUM`.
- `TOT_WIDTH`, 16, width of the emitted-packet counter.

Ports:
- `RCLOCK`, in, 1, single clock.
- `RESET`, in, 1, synchronous active-high reset.
- `FIFO_EMPTY`, in, 1, FIFO empty flag.
- `FIFO_RDATA`, in, `DWIDTH`, head word of the FIFO; valid whenever `FIFO_EMPTY`=0.
- `FIFO_RE`, out, 1, pop strobe; combinational.
- `FLUSH`, in, 1, one-cycle request to close the current partial packet.
- `PKT_DATA`, out, `DWIDTH*PACK_NUM`, packet payload; word k occupies bits [DWIDTH*k+DWIDTH-1 : DWIDTH*k]; the first popped word sits in the LSBs.
- `PKT_CNT`, out, `CNT_WIDTH`, number of valid words in `PKT_DATA` (1..`PACK_NUM`).
- `PKT_VALID`, out, 1, packet available.
- `PKT_READY`, in, 1, downstream accept.
- `PKT_TOTAL`, out, `TOT_WIDTH`, count of accepted packets; wraps.
- `BUSY`, out, 1, high when `wcnt`≠0, `flush_pend`=1 or `PKT_VALID`=1.

## Operation
- State:
  - accumulator `acc`, with word count `wcnt` (0..`PACK_NUM`);
  - flag `flush_pend`;
  - output register holding `PKT_DATA`, `PKT_CNT` and `PKT_VALID`.
- Output free: `ofree` = !`PKT_VALID` | `PKT_READY`.
- Transfer: `xfer` = `ofree` & ((`wcnt`==`PACK_NUM`) | (`flush_pend` & `wcnt`≠0)).
  - On `xfer`, the output register loads `acc`; unused upper words are zero.
  - `PKT_CNT`<=`wcnt` and `PKT_VALID`<=1.
  - `wcnt` restarts from 0, or from 1 if a pop occurs in the same cycle.
- Pop: `FIFO_RE` = !`RESET` & !`FIFO_EMPTY` & !`flush_pend` & ((`wcnt`<`PACK_NUM`) | `xfer`).
  - The popped word is written at slot `wcnt`, or at slot 0 on an `xfer` cycle.
  - At most one pop per cycle.
- Acceptance: `PKT_VALID` & `PKT_READY` with no `xfer` in the same cycle clears `PKT_VALID`.
  - Every acceptance increments `PKT_TOTAL`.
- Flush:
  - `FLUSH`=1 sets `flush_pend`, which blocks pops from the following cycle on.
  - A pop occurring in the same cycle as `FLUSH` is included in the closing packet.
  - `flush_pend` clears on the `xfer` it causes, or on the next cycle if `wcnt`==0 (no packet is emitted).
  - `FLUSH` while `flush_pend`=1 has no additional effect.
  - If `wcnt`==`PACK_NUM` when a flush is pending, the result is one normal full packet, then the flush clears.
- Backpressure: while `PKT_VALID`=1 and `PKT_READY`=0, `acc` may fill to `PACK_NUM`. Popping then stalls; no data is lost or reordered.

## Timing
- Reset, sampled on a `RCLOCK` rising edge, forces:
  - `PKT_VALID`=0, `PKT_DATA`=0, `PKT_CNT`=0, `PKT_TOTAL`=0;
  - `wcnt`=0, `flush_pend`=0, `BUSY`=0.
  - `FIFO_RE` is 0 during reset.
- Reset mid-packet discards `acc` and the output register. Words already popped are lost; this is intended.
- Latency: the edge that pops the `PACK_NUM`-th word is followed by `PKT_VALID`=1 after the next edge, provided `ofree`.
- Throughput: with the FIFO never empty and `PKT_READY`=1, there is one pop every cycle and one packet every `PACK_NUM` cycles, with no bubbles.
- Flush latency: `PKT_VALID` rises 2 edges after the `FLUSH` cycle when `ofree`.
- Handshake: `PKT_DATA` and `PKT_CNT` are stable while `PKT_VALID`=1 and `PKT_READY`=0.

## Structure
- Shared package `bfifo_pkg`: `DWIDTH`, `PACK_NUM` and `CNT_WIDTH` defaults, plus the packet width constant `PKT_WIDTH`=`DWIDTH*PACK_NUM`.
- One sub-module, `bfifo_pkt_oreg`: the output register with valid/ready hold and the `PKT_TOTAL` counter.
- The accumulator, pop logic and flush logic stay in the top module.

## Test plan
- Continuous words 0..7 repeating, with `PKT_READY`=1 and defaults:
  - `FIFO_RE` is high 16 consecutive cycles;
  - two packets are emitted, each `PKT_DATA`=24'hFAC688, `PKT_CNT`=8;
  - `PKT_TOTAL`=2.
- Three words 5,6,7, then `FLUSH`:
  - one packet with `PKT_DATA`=24'h0001F5 and `PKT_CNT`=3, two edges after `FLUSH`.
- `FLUSH` with `wcnt`=0:
  - no `PKT_VALID`; `flush_pend` clears after one cycle; `BUSY` returns to 0.
- `PKT_READY`=0 for 20 cycles with the FIFO full:
  - the first packet is held stable;
  - `FIFO_RE` stops after 8 more pops (`acc` full);
  - on release, packets arrive in order and `PKT_TOTAL` increments per accept.
- `FLUSH` in the same cycle as the 4th pop:
  - the closing packet has `PKT_CNT`=4 and includes that word.
- `RESET` asserted with `wcnt`=5 and `PKT_VALID`=1:
  - all outputs are 0 the next cycle;
  - the next full packet contains only post-reset words.
